fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Framebuffer memory arbiter in the clk100 domain, between a single-port synchronous pixel memory and two requesters: the scan-out line fetcher feeding the 800x600 pixel pipeline, and a drawing writer. Scan-out bursts get priority so the display never underruns. A one-slot fairness rule guarantees the writer bounded latency. Sits between the PLL-clocked pattern/scan-out logic and the frame memory.

## Interface

- ADDR_W, 19: memory word-address width.
- DATA_W, 12: pixel word width (4:4:4 RGB).
- BURST, 8: words per fetch burst (>=1).
- RD_LAT, 2: memory read latency in cycles from address presented to mem_rdata valid (>=1).

- clk100  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  scan-out burst request; held until fetch_ack.
- fetch_addr  in  ADDR_W  burst base address; stable while fetch_req high.
- fetch_ack  out  1  one-cycle pulse: burst accepted, fetch_addr captured.
- fetch_valid  out  1  fetch_data carries a burst word.
- fetch_data  out  DATA_W  read data, in address order.
- wr_req  in  1  single-word write request; held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: the write is issued this cycle.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered write enable.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after its address.
- busy  out  1  state != IDLE.

## Operation

- States: IDLE, FETCH, WRITE. Reset -> IDLE, last_fetch=0.
- IDLE decision, in priority order:
  - fetch_req && !(wr_req && last_fetch) -> FETCH.
  - else wr_req -> WRITE.
  - else stay in IDLE.
- FETCH: exactly BURST cycles. Cycle k (0..BURST-1) drives mem_addr=base+k, mem_we=0. fetch_ack is high in cycle 0 only. Then -> IDLE, last_fetch=1.
- Address arithmetic is modulo 2^ADDR_W; a burst wraps from the all-ones address to 0.
- WRITE: one cycle. mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1. Then -> IDLE, last_fetch=0.
- IDLE drives mem_we=0. mem_addr and mem_wdata hold their last values.
- Read tracking uses an issue-flag shift register of depth RD_LAT+1, independent of state. fetch_data is registered mem_rdata, fetch_valid the delayed issue flag. Reads still in flight complete correctly across later IDLE/WRITE/FETCH states.
- A write issued while reads are in flight is legal; the memory orders operations by issue cycle.
- No back-pressure on fetch_valid; the consumer must accept every word.

## Timing

- Reset values: all outputs 0; the shift register is cleared.
- Reset mid-operation: in the next cycle state=IDLE, mem_we=0, and fetch_valid stays 0 until a new burst's data arrives. No stale words are delivered. The requester re-requests after reset.
- IDLE decision cycle t -> first FETCH/WRITE cycle t+1. At least one IDLE cycle separates grants.
- Fetch latency: first issue at t+1, first fetch_valid at t+2+RD_LAT. BURST consecutive valid cycles follow, with no gaps.
- Write latency bound: a wr_req held from cycle t is acked no later than t+BURST+2.
- fetch_ack and wr_ack are never high in the same cycle.

## Test plan

- Reset: assert reset 3 cycles with requests active -> every output 0 and busy=0 throughout; first grant in the 2nd cycle after release.
- Single fetch at 0x00100 (BURST=8, RD_LAT=2), memory model data=addr[11:0]:
  - fetch_ack is one cycle.
  - mem_addr steps 0x100..0x107 on 8 consecutive cycles.
  - fetch_valid is high for 8 cycles starting 3 cycles after the first issue, with data 0x100..0x107.
- Wrap: fetch_addr=0x7FFFC -> mem_addr sequence 7FFFC,7FFFD,7FFFE,7FFFF,00000,00001,00002,00003, with data in that order.
- Simultaneous request after reset: fetch_req and wr_req rise together:
  - The fetch burst is granted first.
  - The write (addr 0x00050, data 0xABC) follows with mem_we=1 for one cycle and wr_ack the same cycle.
  - Read-back fetch at 0x00050 returns 0xABC.
- Saturation: fetch_req and wr_req held high for 100 cycles -> pattern FETCH(8), IDLE, WRITE, IDLE repeats; each wr_ack arrives within 10 cycles of the prior grant; no fetch_valid gaps inside a burst.
- Reset at the 4th FETCH cycle -> next cycle mem_we=0 and busy=0; no fetch_valid for the interrupted burst; a new fetch then completes normally.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_arbiter_if
//
// Bundles every signal between the framebuffer arbiter and its neighbours:
// the scan-out fetch requester, the drawing writer and the single-port
// pixel memory.
//
//   fetch_req/fetch_addr  -> arbiter   scan-out burst request and base address
//   fetch_ack             <- arbiter   one-cycle burst acceptance pulse
//   fetch_valid/fetch_data<- arbiter   burst read data, in address order
//   wr_req/wr_addr/wr_data-> arbiter   single-word write request
//   wr_ack                <- arbiter   one-cycle pulse, write issued
//   mem_addr/mem_we/mem_wdata <- arbiter   registered memory command
//   mem_rdata             -> arbiter   memory read data
//   busy                  <- arbiter   arbiter is not idle
//
// The slave modport is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  fetch_req, fetch_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output fetch_ack, fetch_valid, fetch_data, wr_ack,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  fetch_ack, fetch_valid, fetch_data, wr_ack,
               mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
//
// Arbitrates a single-port synchronous pixel memory between the scan-out line
// fetcher (BURST-word read bursts, high priority) and a drawing writer
// (single-word writes). After a burst, a waiting writer always gets the next
// slot, which bounds write latency.
//
// Ports:
//   clk100  sole clock, rising edge
//   reset   synchronous, active-high
//   bus     fb_arbiter_if.slave: request/ack handshakes, burst read data
//           and the registered memory command
//
// Parameters: ADDR_W address width, DATA_W pixel width, BURST words per
// fetch, RD_LAT memory read latency in cycles.
// ---------------------------------------------------------------------------
module fb_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12,
    parameter int BURST  = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk100,
    input  logic          reset,
    fb_arbiter_if.slave   bus
);

    localparam int              CNT_W     = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  beat;
    logic              last_fetch;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              mem_we_q;
    logic              mem_we_nx;
    logic              fetch_ack_q;
    logic              fetch_ack_nx;
    logic              wr_ack_q;
    logic              wr_ack_nx;

    // Bit i is set when a read was issued i+1 cycles ago; the top bit lines up
    // with the registered copy of mem_rdata for that read.
    logic [RD_LAT:0]   issue_sr;
    logic [DATA_W-1:0] fetch_data_q;

    // State register plus the burst beat counter and the fairness flag.
    // last_fetch remembers that the most recent grant was a burst, so a
    // waiting writer beats a new fetch request in the following IDLE cycle.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            last_fetch <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && state_nx == FETCH) begin
                beat <= beat + 1'b1;
            end else begin
                beat <= '0;
            end
            if (state == FETCH && state_nx == IDLE) begin
                last_fetch <= 1'b1;
            end else if (state == WRITE) begin
                last_fetch <= 1'b0;
            end
        end
    end

    // Next-state decision. Grants are only made from IDLE, so every grant
    // is separated from the previous one by at least one IDLE cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.fetch_req && !(bus.wr_req && last_fetch)) begin
                    state_nx = FETCH;
                end else if (bus.wr_req) begin
                    state_nx = WRITE;
                end
            end
            FETCH: begin
                if (beat == LAST_BEAT) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode, computed from the upcoming state so the memory command
    // and acks are registered and appear in the same cycle as that state.
    // The burst address increments naturally wrap at 2^ADDR_W.
    always_comb begin
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        mem_we_nx    = 1'b0;
        fetch_ack_nx = 1'b0;
        wr_ack_nx    = 1'b0;
        case (state_nx)
            FETCH: begin
                if (state == IDLE) begin
                    mem_addr_nx  = bus.fetch_addr;
                    fetch_ack_nx = 1'b1;
                end else begin
                    mem_addr_nx  = mem_addr_q + 1'b1;
                end
            end
            WRITE: begin
                mem_addr_nx  = bus.wr_addr;
                mem_wdata_nx = bus.wr_data;
                mem_we_nx    = 1'b1;
                wr_ack_nx    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output registers and read tracking. The issue shift register runs
    // independently of the FSM, so reads in flight finish across any later
    // state; reset clears it so an interrupted burst delivers nothing.
    always_ff @(posedge clk100) begin
        if (reset) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            fetch_ack_q  <= 1'b0;
            wr_ack_q     <= 1'b0;
            issue_sr     <= '0;
            fetch_data_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_nx;
            mem_wdata_q  <= mem_wdata_nx;
            mem_we_q     <= mem_we_nx;
            fetch_ack_q  <= fetch_ack_nx;
            wr_ack_q     <= wr_ack_nx;
            issue_sr     <= {issue_sr[RD_LAT-1:0], (state == FETCH)};
            fetch_data_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.fetch_ack   = fetch_ack_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.fetch_valid = issue_sr[RD_LAT];
    assign bus.fetch_data  = fetch_data_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter
//
// Drives fb_arbiter through directed scenarios against a behavioural memory
// (unwritten words read back as addr[11:0]). A transaction-level model
// schedules, at each arbitration decision, the full set of outputs the grant
// must produce in the following cycles; a negedge process compares every
// cycle. Directed phases add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;
    localparam int BURST     = 8;
    localparam int RD_LAT    = 2;
    localparam int RING      = 32;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic clk100 = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;

    fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BURST (BURST),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk100(clk100),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk100 = ~clk100;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk100) cyc <= cyc + 1;

    // Behavioural single-port memory with RD_LAT cycles of read latency.
    logic [DATA_W-1:0] benchMem     [MEM_WORDS];
    bit                benchWritten [MEM_WORDS];
    logic [DATA_W-1:0] rdPipe       [RD_LAT];

    always @(posedge clk100) begin
        rdPipe[0] <= benchWritten[bus.mem_addr] ? benchMem[bus.mem_addr]
                                                : bus.mem_addr[DATA_W-1:0];
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
        if (bus.mem_we) begin
            benchMem[bus.mem_addr]     <= bus.mem_wdata;
            benchWritten[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_rdata = rdPipe[RD_LAT-1];

    // Expected-output schedule, indexed by cycle modulo RING.
    bit                expBusy    [RING];
    bit                expWe      [RING];
    bit                expFack    [RING];
    bit                expWack    [RING];
    bit                expChkAddr [RING];
    bit                expValid   [RING];
    logic [ADDR_W-1:0] expAddr    [RING];
    logic [DATA_W-1:0] expWdata   [RING];
    logic [DATA_W-1:0] expData    [RING];

    logic [DATA_W-1:0] modelMem     [MEM_WORDS];
    bit                modelWritten [MEM_WORDS];
    int                freeAt       = 0;
    bit                lastWasFetch = 1'b0;

    int  nChecks  = 0;
    int  nErrors  = 0;
    bit  armed    = 1'b0;
    bit  autoDrop = 1'b1;
    bit  fackNow  = 1'b0;
    bit  wackNow  = 1'b0;

    int                fackQ[$];
    int                wackQ[$];
    int                validCycQ[$];
    logic [DATA_W-1:0] gotData[$];
    logic [ADDR_W-1:0] gotAddr[$];

    logic [ADDR_W-1:0] wrapAddr [8] = '{19'h7FFFC, 19'h7FFFD, 19'h7FFFE, 19'h7FFFF,
                                        19'h00000, 19'h00001, 19'h00002, 19'h00003};
    logic [DATA_W-1:0] wrapData [8] = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF,
                                        12'h000, 12'h001, 12'h002, 12'h003};

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
        return modelWritten[a] ? modelMem[a] : a[DATA_W-1:0];
    endfunction

    task automatic clearSlot(input int s);
        expBusy[s]    = 1'b0;
        expWe[s]      = 1'b0;
        expFack[s]    = 1'b0;
        expWack[s]    = 1'b0;
        expChkAddr[s] = 1'b0;
        expValid[s]   = 1'b0;
        expAddr[s]    = '0;
        expWdata[s]   = '0;
        expData[s]    = '0;
    endtask

    // Arbitration rules at transaction level: in a free (decision) cycle,
    // pick the winner and schedule every output cycle of that grant.
    task automatic modelStep();
        logic [ADDR_W-1:0] a;
        int s;
        int v;
        if (reset) begin
            for (int i = 0; i < RING; i++) clearSlot(i);
            freeAt       = cyc + 1;
            lastWasFetch = 1'b0;
            return;
        end
        if (cyc < freeAt) return;
        if (bus.fetch_req && !(bus.wr_req && lastWasFetch)) begin
            for (int k = 0; k < BURST; k++) begin
                a = bus.fetch_addr + ADDR_W'(k);
                s = (cyc + 1 + k) % RING;
                v = (cyc + 2 + RD_LAT + k) % RING;
                expBusy[s]    = 1'b1;
                expChkAddr[s] = 1'b1;
                expAddr[s]    = a;
                expFack[s]    = (k == 0);
                expValid[v]   = 1'b1;
                expData[v]    = modelRead(a);
            end
            freeAt       = cyc + BURST + 1;
            lastWasFetch = 1'b1;
        end else if (bus.wr_req) begin
            s = (cyc + 1) % RING;
            expBusy[s]    = 1'b1;
            expWe[s]      = 1'b1;
            expWack[s]    = 1'b1;
            expChkAddr[s] = 1'b1;
            expAddr[s]    = bus.wr_addr;
            expWdata[s]   = bus.wr_data;
            modelMem[bus.wr_addr]     = bus.wr_data;
            modelWritten[bus.wr_addr] = 1'b1;
            freeAt       = cyc + 2;
            lastWasFetch = 1'b0;
        end
    endtask

    task automatic checkOutput();
        int s;
        s = cyc % RING;
        compare("busy",        32'(bus.busy),        32'(expBusy[s]));
        compare("mem_we",      32'(bus.mem_we),      32'(expWe[s]));
        compare("fetch_ack",   32'(bus.fetch_ack),   32'(expFack[s]));
        compare("wr_ack",      32'(bus.wr_ack),      32'(expWack[s]));
        compare("fetch_valid", 32'(bus.fetch_valid), 32'(expValid[s]));
        if (expChkAddr[s]) compare("mem_addr",   32'(bus.mem_addr),   32'(expAddr[s]));
        if (expWe[s])      compare("mem_wdata",  32'(bus.mem_wdata),  32'(expWdata[s]));
        if (expValid[s])   compare("fetch_data", 32'(bus.fetch_data), 32'(expData[s]));
    endtask

    // Per-cycle compare against the model, then event recording for the
    // directed literal checks.
    always @(negedge clk100) begin
        fackNow = bus.fetch_ack;
        wackNow = bus.wr_ack;
        if (armed) begin
            checkOutput();
            clearSlot(cyc % RING);
            modelStep();
            if (bus.fetch_ack)             fackQ.push_back(cyc);
            if (bus.wr_ack)                wackQ.push_back(cyc);
            if (bus.busy && !bus.mem_we)   gotAddr.push_back(bus.mem_addr);
            if (bus.fetch_valid) begin
                validCycQ.push_back(cyc);
                gotData.push_back(bus.fetch_data);
            end
        end
    end

    // Advance one cycle; requesters drop their request after seeing the ack.
    task automatic tick();
        @(posedge clk100);
        #1;
        if (autoDrop) begin
            if (fackNow) bus.fetch_req = 1'b0;
            if (wackNow) bus.wr_req    = 1'b0;
        end
    endtask

    task automatic clearQueues();
        fackQ.delete();
        wackQ.delete();
        validCycQ.delete();
        gotData.delete();
        gotAddr.delete();
    endtask

    task automatic applyStimulus(input bit doFetch, input logic [ADDR_W-1:0] fa,
                                 input bit doWrite, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd);
        if (doFetch) begin
            bus.fetch_addr = fa;
            bus.fetch_req  = 1'b1;
        end
        if (doWrite) begin
            bus.wr_addr = wa;
            bus.wr_data = wd;
            bus.wr_req  = 1'b1;
        end
    endtask

    task automatic waitAck(input bit forWrite, input int bound);
        int start;
        int i;
        start = forWrite ? wackQ.size() : fackQ.size();
        i = 0;
        while ((forWrite ? wackQ.size() : fackQ.size()) == start && i < bound) begin
            tick();
            i++;
        end
        compare(forWrite ? "wr_ack arrival" : "fetch_ack arrival",
                32'((forWrite ? wackQ.size() : fackQ.size()) > start), 32'd1);
    endtask

    task automatic checkBurstData(input string name, input logic [DATA_W-1:0] first);
        compare({name, " word count"}, 32'(gotData.size()), 32'(BURST));
        for (int k = 0; k < BURST; k++)
            if (gotData.size() > k)
                compare({name, " data"}, 32'(gotData[k]), 32'(first + DATA_W'(k)));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int relCyc;
        int prevF;
        for (int i = 0; i < RING; i++) clearSlot(i);
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;

        // Reset held 3 cycles with both requests already pending.
        reset = 1'b1;
        applyStimulus(1'b1, 19'h00100, 1'b1, 19'h00050, 12'hABC);
        tick();
        armed = 1'b1;
        tick();
        compare("reset busy", 32'(bus.busy), 32'd0);
        compare("reset fetch_ack", 32'(bus.fetch_ack), 32'd0);
        tick();
        reset  = 1'b0;
        relCyc = cyc;
        $display("[TB] reset released at cycle %0d", relCyc);

        // Fetch wins the simultaneous request, write follows.
        waitAck(1'b1, 30);
        repeat (6) tick();
        if (fackQ.size() > 0)     compare("first fetch_ack cycle", fackQ[0], relCyc + 1);
        if (wackQ.size() > 0)     compare("first wr_ack cycle", wackQ[0], relCyc + 10);
        compare("single ack pulse", fackQ.size(), 1);
        if (validCycQ.size() > 7) begin
            compare("first fetch_valid cycle", validCycQ[0], relCyc + 4);
            compare("last fetch_valid cycle", validCycQ[7], relCyc + 11);
        end
        for (int k = 0; k < BURST; k++)
            if (gotAddr.size() > k) compare("burst mem_addr", 32'(gotAddr[k]), 32'h100 + k);
        checkBurstData("fetch 0x100", 12'h100);

        // Read back the word just written.
        clearQueues();
        applyStimulus(1'b1, 19'h00050, 1'b0, '0, '0);
        waitAck(1'b0, 20);
        repeat (12) tick();
        if (gotData.size() > 0) compare("readback 0x50", 32'(gotData[0]), 32'hABC);
        if (gotData.size() > 1) compare("readback 0x51", 32'(gotData[1]), 32'h051);

        // Burst wrapping from the top of the address space.
        clearQueues();
        applyStimulus(1'b1, 19'h7FFFC, 1'b0, '0, '0);
        waitAck(1'b0, 20);
        repeat (12) tick();
        compare("wrap addr count", 32'(gotAddr.size()), 32'(BURST));
        for (int k = 0; k < 8; k++) begin
            if (gotAddr.size() > k) compare("wrap mem_addr", 32'(gotAddr[k]), 32'(wrapAddr[k]));
            if (gotData.size() > k) compare("wrap data", 32'(gotData[k]), 32'(wrapData[k]));
        end

        // Saturation: both requesters continuously asserted.
        clearQueues();
        autoDrop = 1'b0;
        applyStimulus(1'b1, 19'h00200, 1'b1, 19'h00060, 12'h123);
        repeat (100) tick();
        bus.fetch_req = 1'b0;
        bus.wr_req    = 1'b0;
        autoDrop = 1'b1;
        repeat (15) tick();
        compare("sat enough writes", 32'(wackQ.size() >= 8), 32'd1);
        compare("sat word count", validCycQ.size(), BURST * fackQ.size());
        foreach (wackQ[i]) begin
            prevF = -1;
            foreach (fackQ[j]) if (fackQ[j] < wackQ[i]) prevF = fackQ[j];
            if (prevF >= 0) compare("sat wr_ack after fetch grant", wackQ[i] - prevF, 9);
        end
        for (int i = 1; i < validCycQ.size(); i++)
            if (i % BURST != 0) compare("sat burst gap", validCycQ[i] - validCycQ[i-1], 1);

        // Reset taking effect at the 4th fetch cycle of a burst.
        clearQueues();
        applyStimulus(1'b1, 19'h00300, 1'b0, '0, '0);
        waitAck(1'b0, 20);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compare("post-reset busy", 32'(bus.busy), 32'd0);
        compare("post-reset mem_we", 32'(bus.mem_we), 32'd0);
        repeat (10) tick();
        compare("interrupted burst words", 32'(gotData.size()), 32'd0);
        clearQueues();
        applyStimulus(1'b1, 19'h00300, 1'b0, '0, '0);
        waitAck(1'b0, 20);
        repeat (12) tick();
        checkBurstData("refetch 0x300", 12'h300);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
